// File: rtl/hgw_idle_ctrl_if.sv
// Control/status bundle between the idle-gating controller and its surroundings.
// The controller takes the slave view; the environment driving it takes the master view.
interface hgw_idle_ctrl_if #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned STAT_W = 16
);
  logic              busy_i;
  logic              force_on;
  logic [CNT_W-1:0]  idle_thresh;
  logic              req_valid;
  logic              req_ready;
  logic              hw_en;
  logic              gated_o;
  logic [STAT_W-1:0] gate_cnt;

  modport master (
    output busy_i,
    output force_on,
    output idle_thresh,
    output req_valid,
    input  req_ready,
    input  hw_en,
    input  gated_o,
    input  gate_cnt
  );

  modport slave (
    input  busy_i,
    input  force_on,
    input  idle_thresh,
    input  req_valid,
    output req_ready,
    output hw_en,
    output gated_o,
    output gate_cnt
  );
endinterface

// File: rtl/hgw_idle_ctrl.sv
// Idle-detect controller producing the clock enable for a downstream gated domain.
// Drops hw_en after idle_thresh idle cycles, restarts on new work and holds requests off during wake.
module hgw_idle_ctrl #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned WAKE_CYC = 3,
  parameter int unsigned STAT_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst,
  hgw_idle_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {
    StActive   = 2'd0,
    StIdleWait = 2'd1,
    StGated    = 2'd2,
    StWake     = 2'd3
  } state_e;

  localparam logic [3:0]        WakeInit = 4'(WAKE_CYC);
  localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);
  localparam logic [STAT_W-1:0] StatMax  = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [STAT_W-1:0] gate_cnt_q, gate_cnt_d;
  logic              idle;
  logic              enter_gated;

  assign idle = !bus.busy_i && !bus.req_valid && !bus.force_on;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q    <= StActive;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      gate_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      gate_cnt_q <= gate_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    enter_gated = 1'b0;
    unique case (state_q)
      StActive: begin
        // idle_thresh is only sampled here; later changes wait for the next idle run
        if (idle && (bus.idle_thresh != '0)) begin
          if (bus.idle_thresh == CntOne) begin
            state_d     = StGated;
            enter_gated = 1'b1;
          end else begin
            state_d = StIdleWait;
            cnt_d   = bus.idle_thresh - CntOne;
          end
        end
      end
      StIdleWait: begin
        if (!idle) begin
          state_d = StActive;
        end else if (cnt_q == CntOne) begin
          state_d     = StGated;
          enter_gated = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StGated: begin
        if (!idle) begin
          state_d = StWake;
          wcnt_d  = WakeInit;
        end
      end
      StWake: begin
        // No abort back to GATED: the ICG must see a full restart first
        if (wcnt_q == 4'd1) begin
          state_d = StActive;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      default: state_d = StActive;
    endcase
  end

  always_comb begin
    gate_cnt_d = gate_cnt_q;
    if (enter_gated && (gate_cnt_q != StatMax)) begin
      gate_cnt_d = gate_cnt_q + STAT_W'(1);
    end
  end

  // All outputs decode registered state only
  assign bus.hw_en     = (state_q != StGated);
  assign bus.req_ready = (state_q == StActive) || (state_q == StIdleWait);
  assign bus.gated_o   = (state_q == StGated);
  assign bus.gate_cnt  = gate_cnt_q;

endmodule

// File: tb/tb_hgw_idle_ctrl.sv
// Bench for hgw_idle_ctrl: directed stimulus, an idle-streak model checked every cycle,
// and literal expectations at key points. A second instance with a 4-bit counter checks saturation.
module tb_hgw_idle_ctrl;

  localparam int WakeCyc = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic       force_on;
  logic [7:0] thresh;
  logic       req_valid;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  hgw_idle_ctrl_if #(.CNT_W(8), .STAT_W(16)) bus_a ();
  hgw_idle_ctrl_if #(.CNT_W(8), .STAT_W(4))  bus_b ();

  assign bus_a.busy_i      = busy;
  assign bus_a.force_on    = force_on;
  assign bus_a.idle_thresh = thresh;
  assign bus_a.req_valid   = req_valid;
  assign bus_b.busy_i      = busy;
  assign bus_b.force_on    = force_on;
  assign bus_b.idle_thresh = thresh;
  assign bus_b.req_valid   = req_valid;

  hgw_idle_ctrl #(.CNT_W(8), .WAKE_CYC(WakeCyc), .STAT_W(16)) u_dut_a (
    .clk_i (clk),
    .rst   (rst),
    .bus   (bus_a)
  );

  hgw_idle_ctrl #(.CNT_W(8), .WAKE_CYC(WakeCyc), .STAT_W(4)) u_dut_b (
    .clk_i (clk),
    .rst   (rst),
    .bus   (bus_b)
  );

  // Model: clock either gated, waking with some cycles left, or running with an idle streak.
  bit m_gated, n_gated;
  int m_wake,  n_wake;
  int m_streak, n_streak;
  int m_lat,   n_lat;
  int m_gcnt,  n_gcnt;
  int m_xfer,  n_xfer;
  bit m_ready;
  bit idle;

  assign m_ready = !m_gated && (m_wake == 0);

  always_comb begin
    n_gated  = m_gated;
    n_wake   = m_wake;
    n_streak = m_streak;
    n_lat    = m_lat;
    n_gcnt   = m_gcnt;
    n_xfer   = m_xfer;
    idle     = !busy && !req_valid && !force_on;
    if (rst) begin
      n_gated  = 1'b0;
      n_wake   = 0;
      n_streak = 0;
      n_lat    = 0;
      n_gcnt   = 0;
    end else begin
      if (req_valid && m_ready) n_xfer = m_xfer + 1;
      if (m_gated) begin
        if (!idle) begin
          n_gated = 1'b0;
          n_wake  = WakeCyc;
        end
      end else if (m_wake > 0) begin
        n_wake = m_wake - 1;
      end else if (!idle) begin
        n_streak = 0;
      end else begin
        n_lat = (m_streak == 0) ? int'(thresh) : m_lat;
        if (n_lat != 0) begin
          if (m_streak + 1 == n_lat) begin
            n_gated  = 1'b1;
            n_streak = 0;
            n_gcnt   = m_gcnt + 1;
          end else begin
            n_streak = m_streak + 1;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    m_gated  <= n_gated;
    m_wake   <= n_wake;
    m_streak <= n_streak;
    m_lat    <= n_lat;
    m_gcnt   <= n_gcnt;
    m_xfer   <= n_xfer;
    started  <= 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("hw_en",      int'(bus_a.hw_en),     int'(!m_gated));
      check("req_ready",  int'(bus_a.req_ready), int'(m_ready));
      check("gated_o",    int'(bus_a.gated_o),   int'(m_gated));
      check("gate_cnt",   int'(bus_a.gate_cnt),  (m_gcnt > 65535) ? 65535 : m_gcnt);
      check("hw_en_b",    int'(bus_b.hw_en),     int'(!m_gated));
      check("gate_cnt_b", int'(bus_b.gate_cnt),  (m_gcnt > 15) ? 15 : m_gcnt);
    end
  end

  int x0;

  initial begin
    rst = 1'b1; busy = 1'b1; force_on = 1'b0; thresh = 8'd4; req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hw_en", int'(bus_a.hw_en), 1);
    check("rst_ready", int'(bus_a.req_ready), 1);
    check("rst_gated", int'(bus_a.gated_o), 0);
    check("rst_cnt",   int'(bus_a.gate_cnt), 0);
    rst = 1'b0;

    // Idle with threshold 4: enable falls on the 4th idle edge
    busy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("pre_gate_hw_en", int'(bus_a.hw_en), 1);
    end
    @(negedge clk);
    check("gate_hw_en", int'(bus_a.hw_en), 0);
    check("gate_gated", int'(bus_a.gated_o), 1);
    check("gate_cnt1",  int'(bus_a.gate_cnt), 1);

    // Request while gated: enable on wake edge, ready WAKE_CYC edges later, one transfer
    req_valid = 1'b1;
    x0 = m_xfer;
    @(negedge clk);
    check("wake_hw_en", int'(bus_a.hw_en), 1);
    check("wake_ready", int'(bus_a.req_ready), 0);
    repeat (2) begin
      @(negedge clk);
      check("wake_hold_ready", int'(bus_a.req_ready), 0);
    end
    @(negedge clk);
    check("wake_done_ready", int'(bus_a.req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("one_xfer", m_xfer - x0, 1);
    check("post_xfer_hw_en", int'(bus_a.hw_en), 1);

    // busy pulse on 3rd idle cycle restarts the 4-cycle count
    repeat (2) @(negedge clk);
    busy = 1'b1;
    @(negedge clk);
    busy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("restart_hw_en", int'(bus_a.hw_en), 1);
    end
    @(negedge clk);
    check("restart_gate_hw_en", int'(bus_a.hw_en), 0);
    check("restart_gate_cnt",   int'(bus_a.gate_cnt), 2);

    // Threshold change during the idle count has no effect on the running count
    busy = 1'b1;
    repeat (5) @(negedge clk);
    busy = 1'b0;
    @(negedge clk);
    thresh = 8'd1;
    repeat (2) begin
      @(negedge clk);
      check("latched_hw_en", int'(bus_a.hw_en), 1);
    end
    @(negedge clk);
    check("latched_gate_hw_en", int'(bus_a.hw_en), 0);

    // Threshold 0 disables gating
    busy = 1'b1;
    repeat (5) @(negedge clk);
    thresh = 8'd0;
    busy = 1'b0;
    repeat (1000) @(negedge clk);
    check("thresh0_hw_en", int'(bus_a.hw_en), 1);
    check("thresh0_cnt",   int'(bus_a.gate_cnt), 3);

    // force_on keeps the clock running
    thresh = 8'd4;
    force_on = 1'b1;
    repeat (1000) @(negedge clk);
    check("force_hw_en", int'(bus_a.hw_en), 1);
    check("force_cnt",   int'(bus_a.gate_cnt), 3);
    force_on = 1'b0;

    // Reset while gated
    repeat (4) @(negedge clk);
    check("pre_rst_gated", int'(bus_a.gated_o), 1);
    rst = 1'b1;
    @(negedge clk);
    check("gated_rst_hw_en", int'(bus_a.hw_en), 1);
    check("gated_rst_ready", int'(bus_a.req_ready), 1);
    check("gated_rst_gated", int'(bus_a.gated_o), 0);
    check("gated_rst_cnt",   int'(bus_a.gate_cnt), 0);
    rst = 1'b0;

    // 21 gate events: the 4-bit counter saturates at 15
    thresh = 8'd1;
    busy = 1'b1;
    @(negedge clk);
    repeat (20) begin
      busy = 1'b0;
      @(negedge clk);
      busy = 1'b1;
      repeat (4) @(negedge clk);
    end
    busy = 1'b0;
    @(negedge clk);
    check("sat_cnt_b", int'(bus_b.gate_cnt), 15);
    check("sat_cnt_a", int'(bus_a.gate_cnt), 21);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
